led_frame_sequencer: RTL
========================

Name: led_frame_sequencer

Overview:
Upstream pattern source for the 4-bit serial LED driver. It generates one 4-bit LED frame per programmable interval, using one of four animation modes. Each frame is offered to the driver over a valid/ready handshake. It sits between the top-level control inputs and the driver's `in`/`enable` ports, and runs on the same 5 MHz clock.

Parameters:
- FRAME_TICKS, 200000, clock cycles between frame generations (40 ms at 5 MHz); minimum 2.
- TICK_W, 32, width of the interval counter; must hold FRAME_TICKS-1.

Ports:
- CLOCK_5  input  1  system clock, 5 MHz.
- n_reset  input  1  reset, asynchronous assert, active-low.
- enable  input  1  run request; level-sensitive.
- mode  input  2  animation: 00 static, 01 binary count, 10 walking one, 11 blink.
- static_pattern  input  4  pattern used by static and blink modes.
- led_ready  input  1  downstream driver can accept a frame.
- led_data  output  4  frame value; stable while led_valid=1.
- led_valid  output  1  frame offered.
- frame_count  output  8  count of accepted frames, wraps 255->0.
- overrun  output  1  sticky: an interval elapsed while a frame was still unaccepted.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (n_reset=0, any time, asynchronous) forces these values:
  - state=IDLE, led_data=0, led_valid=0, frame_count=0, overrun=0, busy=0.
  - tick counter=0, internal pattern register=0, blink phase=0.
  - All outputs are registered.
- States: IDLE, GEN, OFFER, WAIT.
- IDLE: if enable=1, go to GEN next cycle and clear the tick counter.
- GEN (one cycle): compute the next pattern from mode, load led_data, assert led_valid, go to OFFER.
  - 00: led_data=static_pattern.
  - 01: pattern=pattern+1, 4-bit, wraps 1111->0000. The first frame after IDLE is 0001.
  - 10: rotate left; 0001->0010->0100->1000->0001. A zero pattern is seeded to 0001.
  - 11: phase toggles each frame. Phase 1 gives static_pattern, phase 0 gives 0000. The first frame after IDLE is phase 1.
- Mode change: mode is sampled only in GEN. If it differs from the mode latched at the previous GEN, the pattern register is reseeded (count 0000 then +1; walk 0001; blink phase 1) before the frame is computed.
- OFFER: led_valid=1 and led_data held.
  - Handshake completes on any cycle with led_valid & led_ready = 1 (a single-cycle handshake is allowed).
  - On completion: led_valid=0 next cycle, frame_count increments, go to WAIT.
- WAIT: the tick counter runs every cycle from the start of GEN.
  - When the counter reaches FRAME_TICKS-1 it resets to 0.
  - If enable=1, go to GEN; else go to IDLE.
- Frame period is exactly FRAME_TICKS cycles, from GEN to GEN, when led_ready is immediate.
- Overrun: if the counter hits FRAME_TICKS-1 while in OFFER, set overrun (sticky until reset) and let the counter wrap. The frame stays offered unchanged; no frame is dropped or replaced. GEN follows one full interval after the eventual acceptance.
- enable deasserted during OFFER: the offered frame stays valid until accepted (valid is never withdrawn), then the block returns to IDLE.
- enable deasserted during WAIT: go to IDLE at the interval end. enable=0 in IDLE or GEN has no extra effect.
- led_ready while led_valid=0 is ignored.
- static_pattern changes during OFFER do not alter led_data.

Decomposition:
- Shared package holds:
  - mode encodings MODE_STATIC/MODE_COUNT/MODE_WALK/MODE_BLINK;
  - state encodings for IDLE/GEN/OFFER/WAIT;
  - LED_W=4.
- One natural sub-module: led_frame_timer.
  - Holds the TICK_W counter with clear and wrap at FRAME_TICKS-1.
  - Emits a one-cycle interval_done pulse.
- Pattern generation stays inline as a combinational next-pattern function.

Test Plan:
- FRAME_TICKS=4, mode=01, led_ready tied 1, enable=1 -> led_data sequence 0001,0010,...,1111,0000 with GEN every 4 cycles; frame_count reaches 16, then 17 at the 17th frame; overrun stays 0.
- mode=10, ready=1 -> 0001,0010,0100,1000,0001. Switch to mode 11 with static_pattern=1010 -> 1010,0000,1010.
- FRAME_TICKS=4, led_ready held 0 for 10 cycles after valid -> led_data constant throughout; overrun=1 at the 4th cycle; frame_count unchanged until ready=1, then +1.
- enable dropped while in OFFER, ready delayed 3 cycles -> valid held 3 cycles, accepted once, then IDLE; busy=0; no further frames.
- n_reset pulsed low mid-OFFER (asynchronous, between clock edges) -> led_valid, led_data, frame_count and overrun all 0 immediately. After release with enable=1, the first count-mode frame is 0001.
- Single-cycle handshake (ready=1 coincident with the first valid cycle) -> valid for exactly 1 cycle; frame_count +1.

Source files
------------

// File: rtl/led_frame_sequencer_pkg.sv
// Shared encodings for the LED frame sequencer.
// Mode and FSM state constants plus frame width.
package led_frame_sequencer_pkg;

  localparam int LED_W = 4;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_COUNT  = 2'b01;
  localparam logic [1:0] MODE_WALK   = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_GEN   = 2'b01;
  localparam logic [1:0] S_OFFER = 2'b10;
  localparam logic [1:0] S_WAIT  = 2'b11;

endpackage

// File: rtl/led_frame_sequencer_timer.sv
// Frame interval counter for the LED frame sequencer.
// Wraps at FRAME_TICKS-1 and flags that cycle.
module led_frame_timer #(
  parameter int FRAME_TICKS = 200000,
  parameter int TICK_W      = 32
) (
  input  logic CLOCK_5,
  input  logic n_reset,
  input  logic clear,
  input  logic run,
  output logic interval_done
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(FRAME_TICKS - 1);

  logic [TICK_W-1:0] count;

  assign interval_done = run && (count == LAST);

  always_ff @(posedge CLOCK_5 or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= interval_done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Animated LED frame source feeding the serial LED driver.
// One frame per interval, offered over valid/ready.
module led_frame_sequencer
  import led_frame_sequencer_pkg::*;
#(
  parameter int FRAME_TICKS = 200000,
  parameter int TICK_W      = 32
) (
  input  logic             CLOCK_5,
  input  logic             n_reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [LED_W-1:0] static_pattern,
  input  logic             led_ready,
  output logic [LED_W-1:0] led_data,
  output logic             led_valid,
  output logic [7:0]       frame_count,
  output logic             overrun,
  output logic             busy
);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [1:0]       mode_q;
  logic [LED_W-1:0] pattern;
  logic             phase;
  logic             ovr_pend;
  logic             done;
  logic             accept;
  logic             tmr_clear;
  logic             mode_chg;
  logic [LED_W-1:0] base_pat;
  logic             base_ph;
  logic [LED_W-1:0] frame;

  // blink shows the pattern when the toggled phase becomes 1
  function automatic logic [LED_W-1:0] next_frame(
    input logic [1:0]       m,
    input logic [LED_W-1:0] pat,
    input logic             ph,
    input logic [LED_W-1:0] stat
  );
    logic [LED_W-1:0] f;
    f = stat;
    unique case (1'b1)
      (m == MODE_COUNT): f = pat + 1'b1;
      (m == MODE_WALK):
        f = (pat == '0) ? LED_W'(1) : {pat[LED_W-2:0], pat[LED_W-1]};
      (m == MODE_BLINK): f = ph ? '0 : stat;
      (m == MODE_STATIC): f = stat;
    endcase
    return f;
  endfunction

  assign accept    = led_valid && led_ready;
  assign mode_chg  = (mode != mode_q);
  assign base_pat  = mode_chg ? '0 : pattern;
  assign base_ph   = mode_chg ? 1'b0 : phase;
  assign frame     = next_frame(mode, base_pat, base_ph, static_pattern);
  // a late acceptance restarts the interval so WAIT is a full period
  assign tmr_clear = (state == S_IDLE) || (accept && (ovr_pend || done));

  led_frame_timer #(
    .FRAME_TICKS(FRAME_TICKS),
    .TICK_W     (TICK_W)
  ) u_timer (
    .CLOCK_5      (CLOCK_5),
    .n_reset      (n_reset),
    .clear        (tmr_clear),
    .run          (state != S_IDLE),
    .interval_done(done)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (enable) next_state = S_GEN;
      S_GEN:   next_state = S_OFFER;
      S_OFFER: if (accept) next_state = enable ? S_WAIT : S_IDLE;
      S_WAIT:  if (done) next_state = enable ? S_GEN : S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_5 or negedge n_reset) begin
    if (!n_reset) begin
      state       <= S_IDLE;
      mode_q      <= MODE_STATIC;
      pattern     <= '0;
      phase       <= 1'b0;
      ovr_pend    <= 1'b0;
      led_data    <= '0;
      led_valid   <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != S_IDLE);
      if (state == S_IDLE) begin
        pattern <= '0;
        phase   <= 1'b0;
      end
      if (state == S_GEN) begin
        led_data  <= frame;
        led_valid <= 1'b1;
        mode_q    <= mode;
        if (mode == MODE_COUNT || mode == MODE_WALK) pattern <= frame;
        if (mode == MODE_BLINK) phase <= ~base_ph;
      end
      if (state == S_OFFER && done) begin
        overrun  <= 1'b1;
        ovr_pend <= 1'b1;
      end
      if (accept) begin
        led_valid   <= 1'b0;
        ovr_pend    <= 1'b0;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule
